// File: rtl/serial_pattern_pkg.sv
// serial_pattern_pkg: shared types, default parameters and bit-index helpers for
// serial_pattern_gen.
//   state_e            FSM encoding (IDLE=00, RUN=01, DONE=10; 11 is illegal)
//   DEF_*              default parameter values
//   first_bit/last_bit index of the first/last bit emitted from a word
package serial_pattern_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_e;

    localparam int unsigned DEF_WIDTH     = 8;
    localparam int unsigned DEF_DEPTH     = 16;
    localparam int unsigned DEF_ERR_W     = 8;
    localparam bit          DEF_MSB_FIRST = 1'b1;

    function automatic int unsigned first_bit(int unsigned width, bit msb_first);
        return msb_first ? width - 1 : 0;
    endfunction

    function automatic int unsigned last_bit(int unsigned width, bit msb_first);
        return msb_first ? 0 : width - 1;
    endfunction

endpackage

// File: rtl/pattern_mem.sv
// pattern_mem: DEPTH x WIDTH pattern storage, synchronous write, asynchronous read.
//   clk_i    clock
//   we_i     write strobe (already gated by the parent)
//   waddr_i  write address
//   wdata_i  write data
//   raddr_i  read address
//   rdata_o  combinational read data
// Contents are not reset.
module pattern_mem #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/serial_pattern_gen.sv
// serial_pattern_gen: streams NWORDS pattern words bit-serially on G and compares each
// bit against X, counting mismatches (saturating) and giving a match verdict Z.
//   CLK, CLR                      clock, synchronous active-high reset
//   START, NWORDS                 begin a run of NWORDS words (0 = DEPTH), IDLE only
//   LOAD_EN, LOAD_ADDR, LOAD_DATA pattern memory write port (ignored while running)
//   X                             serial bit compared against G
//   G, G_VALID, BUSY              serial pattern bit, valid/busy during RUN
//   DONE                          one-cycle pulse after the final bit
//   Z, ERR_CNT                    last-run verdict and mismatch count
module serial_pattern_gen
    import serial_pattern_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned DEPTH     = DEF_DEPTH,
    parameter int unsigned ADDR_W    = $clog2(DEPTH),
    parameter int unsigned BIT_W     = $clog2(WIDTH),
    parameter int unsigned ERR_W     = DEF_ERR_W,
    parameter bit          MSB_FIRST = DEF_MSB_FIRST
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              START,
    input  logic [ADDR_W-1:0] NWORDS,
    input  logic              LOAD_EN,
    input  logic [ADDR_W-1:0] LOAD_ADDR,
    input  logic [WIDTH-1:0]  LOAD_DATA,
    input  logic              X,
    output logic              G,
    output logic              G_VALID,
    output logic              BUSY,
    output logic              DONE,
    output logic              Z,
    output logic [ERR_W-1:0]  ERR_CNT
);

    // One extra bit so a full-depth run (DEPTH words) is representable.
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [BIT_W-1:0] FIRST_BIT = BIT_W'(first_bit(WIDTH, MSB_FIRST));
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(last_bit(WIDTH, MSB_FIRST));

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] word_ptr_q, word_ptr_d;
    logic [BIT_W-1:0]  bit_ptr_q, bit_ptr_d;
    logic [CNT_W-1:0]  words_left_q, words_left_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic              z_q, z_d;

    logic [WIDTH-1:0]  rdata;
    logic              mem_we;
    logic              mismatch;

    assign mem_we = LOAD_EN && ((state_q == S_IDLE) || (state_q == S_DONE));

    pattern_mem #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk_i   (CLK),
        .we_i    (mem_we),
        .waddr_i (LOAD_ADDR),
        .wdata_i (LOAD_DATA),
        .raddr_i (word_ptr_q),
        .rdata_o (rdata)
    );

    assign G        = rdata[bit_ptr_q];
    assign mismatch = X ^ G;

    always_comb begin
        state_d      = state_q;
        word_ptr_d   = word_ptr_q;
        bit_ptr_d    = bit_ptr_q;
        words_left_d = words_left_q;
        err_d        = err_q;
        z_d          = z_q;

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d      = S_RUN;
                    // NWORDS == 0 sets the top bit alone, i.e. DEPTH words.
                    words_left_d = {NWORDS == '0, NWORDS};
                    word_ptr_d   = '0;
                    bit_ptr_d    = FIRST_BIT;
                    err_d        = '0;
                    z_d          = 1'b0;
                end
            end
            S_RUN: begin
                if (mismatch && (err_q != '1)) begin
                    err_d = err_q + ERR_W'(1);
                end
                if (bit_ptr_q == LAST_BIT) begin
                    bit_ptr_d    = FIRST_BIT;
                    word_ptr_d   = word_ptr_q + ADDR_W'(1);
                    words_left_d = words_left_q - CNT_W'(1);
                    if (words_left_q == CNT_W'(1)) begin
                        state_d = S_DONE;
                        z_d     = (err_d == '0);
                    end
                end else if (MSB_FIRST) begin
                    bit_ptr_d = bit_ptr_q - BIT_W'(1);
                end else begin
                    bit_ptr_d = bit_ptr_q + BIT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q      <= S_IDLE;
            word_ptr_q   <= '0;
            bit_ptr_q    <= FIRST_BIT;
            words_left_q <= '0;
            err_q        <= '0;
            z_q          <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_ptr_q   <= word_ptr_d;
            bit_ptr_q    <= bit_ptr_d;
            words_left_q <= words_left_d;
            err_q        <= err_d;
            z_q          <= z_d;
        end
    end

    assign G_VALID = (state_q == S_RUN);
    assign BUSY    = (state_q == S_RUN);
    assign DONE    = (state_q == S_DONE);
    assign Z       = z_q;
    assign ERR_CNT = err_q;

endmodule

// File: tb/tb_serial_pattern_gen.sv
// tb_serial_pattern_gen: drives two instances off one stimulus stream:
//   dut1 defaults (8-bit error counter, MSB first)
//   dut2 4-bit error counter, LSB first
// Expected bits come from a word array indexed by run position.
module tb_serial_pattern_gen;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       CLR = 1'b1;
    logic       START = 1'b0;
    logic [3:0] NWORDS = '0;
    logic       LOAD_EN = 1'b0;
    logic [3:0] LOAD_ADDR = '0;
    logic [7:0] LOAD_DATA = '0;
    logic       X1 = 1'b0, X2 = 1'b0;

    logic       G1, GV1, BUSY1, DONE1, Z1;
    logic [7:0] ERR1;
    logic       G2, GV2, BUSY2, DONE2, Z2;
    logic [3:0] ERR2;

    serial_pattern_gen dut1 (
        .CLK(clk), .CLR(CLR), .START(START), .NWORDS(NWORDS), .LOAD_EN(LOAD_EN),
        .LOAD_ADDR(LOAD_ADDR), .LOAD_DATA(LOAD_DATA), .X(X1), .G(G1), .G_VALID(GV1),
        .BUSY(BUSY1), .DONE(DONE1), .Z(Z1), .ERR_CNT(ERR1)
    );

    serial_pattern_gen #(.ERR_W(4), .MSB_FIRST(1'b0)) dut2 (
        .CLK(clk), .CLR(CLR), .START(START), .NWORDS(NWORDS), .LOAD_EN(LOAD_EN),
        .LOAD_ADDR(LOAD_ADDR), .LOAD_DATA(LOAD_DATA), .X(X2), .G(G2), .G_VALID(GV2),
        .BUSY(BUSY2), .DONE(DONE2), .Z(Z2), .ERR_CNT(ERR2)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [7:0] ref_mem [DEPTH];

    typedef struct {
        int   nw;
        int   fa;
        int   fb;
        int   e1;
        logic z1;
        logic inv2;
        int   e2;
        logic z2;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Bit k of a run: word k/WIDTH (wrapping), bit position per emission order.
    function automatic logic model_bit(int k, bit msb);
        int w;
        int b;
        w = (k / WIDTH) % DEPTH;
        b = k % WIDTH;
        return ref_mem[w][msb ? (WIDTH - 1 - b) : b];
    endfunction

    task automatic load(input int addr, input logic [7:0] data);
        LOAD_EN = 1'b1;
        LOAD_ADDR = 4'(addr);
        LOAD_DATA = data;
        @(posedge clk); #1;
        LOAD_EN = 1'b0;
        ref_mem[addr] = data;
    endtask

    // Full run; X of each dut = expected bit XOR its flip vector. Called at posedge+1 in IDLE.
    task automatic do_run(input int nw, input logic [127:0] f1, input logic [127:0] f2,
                          input int inj, output logic [127:0] cap, output int e1,
                          output logic z1o, output int e2, output logic z2o);
        int n;
        int m1;
        int m2;
        logic b1;
        logic b2;
        n = ((nw == 0) ? DEPTH : nw) * WIDTH;
        START = 1'b1;
        NWORDS = 4'(nw);
        @(posedge clk); #1;
        START = 1'b0;
        m1 = 0;
        m2 = 0;
        cap = '0;
        for (int k = 0; k < n; k++) begin
            if (k == inj) begin
                START = 1'b1;
                LOAD_EN = 1'b1;
                LOAD_ADDR = 4'd0;
                LOAD_DATA = 8'h00;
            end else if (inj >= 0 && k == inj + 1) begin
                START = 1'b0;
                LOAD_EN = 1'b0;
            end
            b1 = model_bit(k, 1'b1);
            b2 = model_bit(k, 1'b0);
            check("g1_bit", int'(G1), int'(b1));
            check("g2_bit", int'(G2), int'(b2));
            check("run_flags", int'({GV1, BUSY1, DONE1, GV2, BUSY2, DONE2}), 6'b110110);
            cap[k] = G1;
            X1 = b1 ^ f1[k];
            X2 = b2 ^ f2[k];
            if (f1[k]) m1++;
            if (f2[k]) m2++;
            @(posedge clk); #1;
        end
        START = 1'b0;
        LOAD_EN = 1'b0;
        if (m1 > 255) m1 = 255;
        if (m2 > 15) m2 = 15;
        check("done_flags", int'({GV1, BUSY1, DONE1, GV2, BUSY2, DONE2}), 6'b001001);
        check("err1_done", int'(ERR1), m1);
        check("z1_done", int'(Z1), int'(m1 == 0));
        check("err2_done", int'(ERR2), m2);
        check("z2_done", int'(Z2), int'(m2 == 0));
        e1 = int'(ERR1);
        z1o = Z1;
        e2 = int'(ERR2);
        z2o = Z2;
        START = 1'b1;  // must be ignored while DONE
        @(posedge clk); #1;
        START = 1'b0;
        check("idle_flags", int'({GV1, BUSY1, DONE1, GV2, BUSY2, DONE2}), 0);
        check("err1_hold", int'(ERR1), m1);
        check("z1_hold", int'(Z1), int'(m1 == 0));
    endtask

    initial begin
        vec_t vecs[5];
        logic [127:0] cap;
        logic [127:0] f1;
        logic [127:0] f2;
        logic [15:0] exp_seq;
        int e1;
        int e2;
        logic z1;
        logic z2;

        exp_seq = 16'b0101_0101_0011_0011;  // bit 0 is the first bit emitted
        vecs[0] = '{nw: 2, fa: -1, fb: -1, e1: 0, z1: 1'b1, inv2: 1'b0, e2: 0,  z2: 1'b1};
        vecs[1] = '{nw: 2, fa: 3,  fb: 10, e1: 2, z1: 1'b0, inv2: 1'b0, e2: 0,  z2: 1'b1};
        vecs[2] = '{nw: 1, fa: 0,  fb: -1, e1: 1, z1: 1'b0, inv2: 1'b0, e2: 0,  z2: 1'b1};
        vecs[3] = '{nw: 3, fa: 23, fb: -1, e1: 1, z1: 1'b0, inv2: 1'b0, e2: 0,  z2: 1'b1};
        vecs[4] = '{nw: 2, fa: -1, fb: -1, e1: 0, z1: 1'b1, inv2: 1'b1, e2: 15, z2: 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        CLR = 1'b0;
        check("reset_flags", int'({GV1, BUSY1, DONE1, Z1, GV2, BUSY2, DONE2, Z2}), 0);
        check("reset_err1", int'(ERR1), 0);
        check("reset_err2", int'(ERR2), 0);

        load(0, 8'hCC);
        load(1, 8'hAA);
        load(2, 8'h5A);

        // Directed table
        foreach (vecs[i]) begin
            f1 = '0;
            if (vecs[i].fa >= 0) f1[vecs[i].fa] = 1'b1;
            if (vecs[i].fb >= 0) f1[vecs[i].fb] = 1'b1;
            f2 = vecs[i].inv2 ? '1 : '0;
            do_run(vecs[i].nw, f1, f2, -1, cap, e1, z1, e2, z2);
            check("vec_err1", e1, vecs[i].e1);
            check("vec_z1", int'(z1), int'(vecs[i].z1));
            check("vec_err2", e2, vecs[i].e2);
            check("vec_z2", int'(z2), int'(vecs[i].z2));
            if (vecs[i].nw == 2) check("vec_seq", int'(cap[15:0]), int'(exp_seq));
        end

        // Mid-run abort at bit 5, after five mismatches on dut1
        START = 1'b1;
        NWORDS = 4'd2;
        @(posedge clk); #1;
        START = 1'b0;
        for (int k = 0; k < 5; k++) begin
            X1 = ~model_bit(k, 1'b1);
            X2 = model_bit(k, 1'b0);
            @(posedge clk); #1;
        end
        check("abort_pre_err", int'(ERR1), 5);
        CLR = 1'b1;
        @(posedge clk); #1;
        CLR = 1'b0;
        check("abort_flags", int'({GV1, BUSY1, DONE1, Z1, GV2, BUSY2, DONE2, Z2}), 0);
        check("abort_err1", int'(ERR1), 0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("abort_no_done", int'({BUSY1, DONE1, Z1, DONE2}), 0);
        end
        do_run(2, '0, '0, -1, cap, e1, z1, e2, z2);
        check("replay_seq", int'(cap[15:0]), int'(exp_seq));

        // START and a write to mem[0] during RUN are ignored
        do_run(2, '0, '0, 4, cap, e1, z1, e2, z2);
        check("inj_seq", int'(cap[15:0]), int'(exp_seq));
        do_run(2, '0, '0, -1, cap, e1, z1, e2, z2);
        check("inj_mem0", int'(cap[7:0]), int'(exp_seq[7:0]));

        // Full-depth run (NWORDS=0 -> 128 bits)
        for (int a = 0; a < DEPTH; a++) load(a, 8'($urandom));
        do_run(0, '0, '0, -1, cap, e1, z1, e2, z2);
        check("full_z1", int'(z1), 1);

        // Randomized runs against the model
        for (int r = 0; r < 8; r++) begin
            for (int a = 0; a < 4; a++) load(int'($urandom_range(0, DEPTH - 1)), 8'($urandom));
            f1 = {$urandom, $urandom, $urandom, $urandom};
            f2 = {$urandom, $urandom, $urandom, $urandom};
            if (r == 0) f1 = '0;
            do_run(int'($urandom_range(0, DEPTH - 1)), f1, f2, -1, cap, e1, z1, e2, z2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_pattern_gen.md
# serial_pattern_gen

Parametrised serial pattern generator and checker: a DEPTH×WIDTH pattern memory is loaded over a write port. START then streams a programmable number of words out bit-serially on G, one bit per CLK. Each emitted bit is compared against the serial input X; mismatches are counted, and a match verdict Z is produced at the end. This block succeeds the fixed 16×8 memory / 4-bit + 3-bit counter / mux datapath, and sits between the stimulus source and the serial link under test.

## Interface
- WIDTH, 8: bits per pattern word; power of two, ≥2.
- DEPTH, 16: words in pattern memory; power of two, ≥2.
- ADDR_W, $clog2(DEPTH): word-address width.
- BIT_W, $clog2(WIDTH): bit-index width.
- ERR_W, 8: mismatch-counter width.
- MSB_FIRST, 1: 1 = bit WIDTH-1 of each word sent first; 0 = bit 0 first.
- CLK  in  1  clock; all state updates on posedge.
- CLR  in  1  reset; synchronous, active-high.
- START  in  1  begin a run; sampled only in IDLE.
- NWORDS  in  ADDR_W  words per run; sampled with START; 0 means DEPTH.
- LOAD_EN  in  1  memory write strobe.
- LOAD_ADDR  in  ADDR_W  write address.
- LOAD_DATA  in  WIDTH  write data.
- X  in  1  serial bit compared against G.
- G  out  1  current serial pattern bit.
- G_VALID  out  1  G is meaningful (state RUN).
- BUSY  out  1  run in progress (RUN).
- DONE  out  1  one-cycle pulse after the final bit.
- Z  out  1  1 = the last run had zero mismatches; sticky until next START or CLR.
- ERR_CNT  out  ERR_W  mismatches in the current or last run; saturating.

## Operation
- States: IDLE (00), RUN (01), DONE (10). Code 11 is illegal; it returns to IDLE on the next edge.
- IDLE: START=1 moves to RUN. It also latches the word count, sets word_ptr=0, sets bit_ptr to the first bit (WIDTH-1 if MSB_FIRST, else 0), clears ERR_CNT and clears Z.
- RUN:
  - G = mem[word_ptr][bit_ptr]. Memory read is combinational.
  - At each edge, if X≠G then ERR_CNT increments, saturating at all-ones.
  - bit_ptr steps toward the last bit. When it passes the last bit, it reloads the first bit and word_ptr increments.
- RUN exit: at the edge that consumes bit NWORDS×WIDTH-1, the state moves to DONE. Z is set to 1 iff the final ERR_CNT, including this bit, is 0.
- DONE: DONE=1 for exactly one cycle, then IDLE. START is ignored in DONE.
- START while in RUN or DONE: ignored; no restart and no queueing.
- LOAD_EN=1 in IDLE or DONE writes LOAD_DATA to mem[LOAD_ADDR] at the edge. In RUN, LOAD_EN is ignored, so the active pattern is never corrupted.
- Memory contents are unaffected by CLR and undefined until written.
- NWORDS=0 runs DEPTH words. word_ptr wraps modulo DEPTH, and the run always ends by count, never by wrap.

## Timing
- Reset values:
  - state=IDLE; G_VALID, BUSY, DONE, Z = 0; ERR_CNT=0.
  - G is a don't-care while G_VALID=0; the bench must not check it.
- CLR has priority over all other inputs. Asserted mid-RUN, it aborts the run: from the next cycle all reset values hold, no DONE pulse is issued, and Z stays 0.
- Latency, with START sampled at edge t0:
  - Bit k is on G during cycle (t0+k, t0+k+1) and is compared with X at edge t0+k+1.
  - With N = NWORDS×WIDTH, the final compare is at t0+N.
  - DONE=1 and Z, ERR_CNT final during cycle (t0+N, t0+N+1).
  - IDLE from t0+N+1; the earliest restart is START sampled at t0+N+1.
- A LOAD_EN write at edge t is readable on G at cycle t+1 or later.

## Structure
- Package serial_pattern_pkg holds:
  - state encodings S_IDLE, S_RUN, S_DONE;
  - default parameter constants;
  - the first-bit/last-bit index helper.
- Sub-module pattern_mem: DEPTH×WIDTH, synchronous write, asynchronous read, write-enable gated by the parent.
- Pointer counters, comparator, error counter and FSM live in serial_pattern_gen.

## Test plan
- **Clean run.** Load mem[0]=8'hCC, mem[1]=8'hAA, with NWORDS=2 and MSB_FIRST=1, and drive X=G.
  - G must be 1,1,0,0,1,1,0,0,1,0,1,0,1,0,1,0.
  - DONE pulses at t0+16, with Z=1 and ERR_CNT=0.
- **Mismatches.** Same setup, but invert X at bits 3 and 10 → ERR_CNT=2 and Z=0 at DONE.
- **Full-depth wrap.** NWORDS=0, DEPTH=16, all words loaded → 128 valid bits, word_ptr wraps to 0, and DONE occurs at t0+128.
- **Mid-run abort.** CLR at bit 5, then release → next cycle BUSY=0, G_VALID=0, ERR_CNT=0, Z=0, and no DONE. A new START replays from word 0, bit 0.
- **Ignored inputs.** START and a LOAD_EN write to mem[0] (8'h00) issued during RUN are both ignored: the sequence is unchanged and mem[0] still reads 8'hCC on the next run.
- **Saturation.** ERR_W=4, NWORDS=2, X=~G throughout → ERR_CNT=15 (saturated), Z=0.
